multi_core_lock_arbiter: RTL

//  Generalised global-memory lock arbiter for an N-core tiny_risc_v cluster sharing lock memory.

---
 rtl/multi_core_lock_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/multi_core_lock_arbiter.sv
// Round-robin global-memory lock arbiter for an N-core cluster: one owner at a time,
// ownership held until release, optional hold-time preemption, configurable stall pattern.
module multi_core_lock_arbiter #(
  parameter int N_CORES  = 4,
  parameter int LOCK_ALL = 1,
  parameter int MAX_HOLD = 0,
  parameter int HOLD_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CORES-1:0]         need_lock,
  output logic [N_CORES-1:0]         lock,
  output logic [N_CORES-1:0]         grant,
  output logic [$clog2(N_CORES)-1:0] owner_id,
  output logic                       owner_valid,
  output logic                       preempt
);
  localparam int IDW = $clog2(N_CORES);

  typedef enum logic {FREE, OWNED} state_t;

  state_t            state;
  logic [IDW-1:0]    rr_ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [N_CORES-1:0] cand;
  logic [IDW-1:0]     winner;
  logic               owner_req;
  logic               hold_expired;
  logic               do_preempt;
  logic               take_new;

  function automatic logic [IDW-1:0] rr_pick(input logic [N_CORES-1:0] req,
                                             input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] pick;
    logic           found;
    int             idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      idx = (int'(ptr) + i) % N_CORES;
      if (!found && req[IDW'(idx)]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [N_CORES-1:0] onehot(input logic [IDW-1:0] id);
    return {{(N_CORES-1){1'b0}}, 1'b1} << id;
  endfunction

  function automatic logic [N_CORES-1:0] lock_of(input logic [N_CORES-1:0] g,
                                                 input logic [N_CORES-1:0] req);
    return (LOCK_ALL != 0) ? ~g : (req & ~g);
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
    return (int'(id) == N_CORES - 1) ? '0 : id + 1'b1;
  endfunction

  // Candidates exclude the current owner, so a preemption can never re-elect it.
  always_comb begin
    cand         = need_lock & ~grant;
    owner_req    = (state == OWNED) && need_lock[owner_id];
    hold_expired = (MAX_HOLD > 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    do_preempt   = owner_req && hold_expired && (|cand);
    winner       = rr_pick(cand, rr_ptr);
    take_new     = ((state == FREE) && (|need_lock)) ||
                   ((state == OWNED) && (!owner_req || do_preempt) && (|cand));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FREE;
      lock        <= '0;
      grant       <= '0;
      owner_id    <= '0;
      owner_valid <= 1'b0;
      preempt     <= 1'b0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
    end else begin
      preempt <= 1'b0;
      if (take_new) begin
        state       <= OWNED;
        grant       <= onehot(winner);
        lock        <= lock_of(onehot(winner), need_lock);
        owner_id    <= winner;
        owner_valid <= 1'b1;
        rr_ptr      <= next_ptr(winner);
        hold_cnt    <= '0;
        preempt     <= do_preempt;
      end else if (owner_req) begin
        if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
        lock <= lock_of(grant, need_lock);
      end else begin
        state       <= FREE;
        grant       <= '0;
        lock        <= '0;
        owner_valid <= 1'b0;
        hold_cnt    <= '0;
      end
    end
  end
endmodule
